// File: rtl/sl_tx_channel_if.sv
// sl_tx_channel_if -- commutator <-> SL transmitter channel bus.
//   master (commutator): drives wr_data/data_we, wr_config/config_we;
//                        observes rd_config, rd_status, status_changed, sl0/sl1.
//   slave  (channel)   : the reverse.
interface sl_tx_channel_if #(
  parameter int CONFIG_REG_WIDTH = 16
);
  logic [31:0]                 wr_data;
  logic                        data_we;
  logic [CONFIG_REG_WIDTH-1:0] wr_config;
  logic                        config_we;
  logic [CONFIG_REG_WIDTH-1:0] rd_config;
  logic                        rd_status;
  logic                        status_changed;
  logic                        sl0;
  logic                        sl1;

  modport master (
    output wr_data, data_we, wr_config, config_we,
    input  rd_config, rd_status, status_changed, sl0, sl1
  );

  modport slave (
    input  wr_data, data_we, wr_config, config_we,
    output rd_config, rd_status, status_changed, sl0, sl1
  );
endinterface

// File: rtl/sl_tx_channel.sv
// sl_tx_channel -- one serial-line transmitter channel.
// Serialises a latched word LSB first onto the SL pair: a low pulse on sl1
// is a '1', a low pulse on sl0 is a '0'; each pulse and each pause lasts
// DIV+1 clocks, followed by an inter-word gap of GAP_BITS bit times.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sl_tx_channel_if.slave (write strobes, config readback,
//                busy/status_changed, sl0/sl1 lines)
// Config: [7:0] DIV, [9:8] LEN (8/16/24/32 bits), [10] PAR_EN (odd parity).
// Optional macro SL_TX_PARITY_INJECT_EN: config bit [11] becomes writable
// and, with PAR_EN, inverts the parity bit (even parity) for error injection.
module sl_tx_channel #(
  parameter int                          CONFIG_REG_WIDTH = 16,
  parameter int                          GAP_BITS         = 3,
  parameter logic [CONFIG_REG_WIDTH-1:0] CFG_RESET        = 16'h0001
) (
  input logic           clk,
  input logic           rst_n,
  sl_tx_channel_if.slave bus
);

`ifdef SL_TX_PARITY_INJECT_EN
  localparam logic [CONFIG_REG_WIDTH-1:0] CFG_MASK = 16'h0FFF;
`else
  localparam logic [CONFIG_REG_WIDTH-1:0] CFG_MASK = 16'h07FF;
`endif
  localparam logic [12:0] GAP_HALVES = 13'(GAP_BITS * 2);

  typedef enum logic [1:0] {IDLE, PULSE, PAUSE, GAP} state_t;

  state_t                      state_q, state_d;
  logic [CONFIG_REG_WIDTH-1:0] cfg_q, cfg_d;
  logic [7:0]                  hcnt_q, hcnt_d;
  logic [5:0]                  bcnt_q, bcnt_d;
  logic [12:0]                 gcnt_q, gcnt_d;
  logic [32:0]                 word_q, word_d;
  logic [7:0]                  div_q, div_d;
  logic                        sl0_q, sl0_d, sl1_q, sl1_d;
  logic                        busy_q, busy_d, chg_q, chg_d;

  // Word assembly from the effective (possibly just-written) config
  logic [1:0]  len;
  logic        pen;
  logic [5:0]  ndata;
  logic [5:0]  nbits;
  logic [31:0] dmask;
  logic [31:0] dm;
  logic        par_bit;
  logic [32:0] word_new;
  logic [12:0] gap_load;

  always_comb begin
    // Config writes only land while idle; same-cycle data_we sees the new value
    cfg_d = (bus.config_we && !busy_q) ? (bus.wr_config & CFG_MASK) : cfg_q;
    len   = cfg_d[9:8];
    pen   = cfg_d[10];
    ndata = {1'b0, len, 3'b000} + 6'd8;
    nbits = ndata + {5'd0, pen};
    dmask = {{8{len == 2'd3}}, {8{len >= 2'd2}}, {8{len >= 2'd1}}, 8'hFF};
    dm    = bus.wr_data & dmask;
    par_bit = ~^dm;
`ifdef SL_TX_PARITY_INJECT_EN
    par_bit = par_bit ^ cfg_d[11];
`endif
    // Parity sits just above the last data bit so the shifter sends it last
    word_new = {1'b0, dm} | (33'(par_bit & pen) << ndata);
    gap_load = GAP_HALVES * ({5'd0, div_q} + 13'd1) - 13'd1;
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    word_d  = word_q;
    div_d   = div_q;
    sl0_d   = 1'b1;
    sl1_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.data_we) begin
          state_d = PULSE;
          div_d   = cfg_d[7:0];
          hcnt_d  = cfg_d[7:0];
          bcnt_d  = nbits - 6'd1;
          word_d  = word_new;
          sl1_d   = ~word_new[0];
          sl0_d   = word_new[0];
        end
      end
      PULSE: begin
        if (hcnt_q == 8'd0) begin
          state_d = PAUSE;
          hcnt_d  = div_q;
        end else begin
          hcnt_d = hcnt_q - 8'd1;
          sl1_d  = ~word_q[0];
          sl0_d  = word_q[0];
        end
      end
      PAUSE: begin
        if (hcnt_q != 8'd0) begin
          hcnt_d = hcnt_q - 8'd1;
        end else if (bcnt_q == 6'd0) begin
          state_d = GAP;
          gcnt_d  = gap_load;
        end else begin
          state_d = PULSE;
          hcnt_d  = div_q;
          bcnt_d  = bcnt_q - 6'd1;
          word_d  = word_q >> 1;
          sl1_d   = ~word_q[1];
          sl0_d   = word_q[1];
        end
      end
      GAP: begin
        if (gcnt_q == 13'd0) state_d = IDLE;
        else                 gcnt_d  = gcnt_q - 13'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    chg_d  = (busy_d != busy_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cfg_q   <= CFG_RESET;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      gcnt_q  <= '0;
      word_q  <= '0;
      div_q   <= '0;
      sl0_q   <= 1'b1;
      sl1_q   <= 1'b1;
      busy_q  <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
      word_q  <= word_d;
      div_q   <= div_d;
      sl0_q   <= sl0_d;
      sl1_q   <= sl1_d;
      busy_q  <= busy_d;
      chg_q   <= chg_d;
    end
  end

  assign bus.rd_config      = cfg_q;
  assign bus.rd_status      = busy_q;
  assign bus.status_changed = chg_q;
  assign bus.sl0            = sl0_q;
  assign bus.sl1            = sl1_q;

endmodule

// File: tb/tb_sl_tx_channel.sv
module tb_sl_tx_channel;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sl_tx_channel_if #(.CONFIG_REG_WIDTH(16)) bus();

  sl_tx_channel #(
    .CONFIG_REG_WIDTH(16),
    .GAP_BITS(3),
    .CFG_RESET(16'h0001)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  typedef struct {
    bit b;
    int w;
  } pulse_t;

  pulse_t exp_q[$];
  int     busy_q[$];
  int     total = 0;
  int     bad   = 0;
  bit     chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_pulse(input bit line, input int width);
    pulse_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_pulse actual=sl%0d width=%0d required=none t=%0t", line, width, $time);
    end else begin
      e = exp_q.pop_front();
      check("pulse_line", 32'(line), 32'(e.b));
      check("pulse_width", width, e.w);
    end
  endtask

  // Monitor: measures pulses and busy windows, checks status_changed
  int   w0 = 0, w1 = 0, bc = 0;
  logic prev_st = 1'b0;
  always @(negedge clk) begin
    if (!rst_n || !chk_en) begin
      w0 = 0; w1 = 0; bc = 0;
      prev_st = rst_n ? bus.rd_status : 1'b0;
    end else begin
      if (!bus.sl0 || !bus.sl1) check("lines_not_both_low", 32'(bus.sl0 | bus.sl1), 32'd1);
      if (!bus.sl1) w1++;
      else if (w1 > 0) begin pop_pulse(1'b1, w1); w1 = 0; end
      if (!bus.sl0) w0++;
      else if (w0 > 0) begin pop_pulse(1'b0, w0); w0 = 0; end
      if (bus.rd_status) bc++;
      else if (bc > 0) begin
        if (busy_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_busy actual=%0d required=none", bc);
        end else check("busy_len", bc, busy_q.pop_front());
        bc = 0;
      end
      if (bus.status_changed || (bus.rd_status != prev_st))
        check("status_changed", 32'(bus.status_changed), 32'(bus.rd_status != prev_st));
      prev_st = bus.rd_status;
    end
  end

  task automatic push_word(input logic [31:0] data, input int ndata, input bit pen,
                           input bit par, input int w, input int busy);
    for (int i = 0; i < ndata; i++) exp_q.push_back('{b: data[i], w: w});
    if (pen) exp_q.push_back('{b: par, w: w});
    busy_q.push_back(busy);
  endtask

  task automatic write_cfg(input logic [15:0] v);
    @(negedge clk);
    bus.wr_config = v; bus.config_we = 1'b1;
    @(negedge clk);
    bus.config_we = 1'b0;
  endtask

  task automatic start_data(input logic [31:0] d);
    @(negedge clk);
    bus.wr_data = d; bus.data_we = 1'b1;
    @(negedge clk);
    bus.data_we = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (bus.rd_status && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (bus.rd_status) begin
      total++; bad++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
    end
    repeat (3) @(negedge clk);
    #1;
    check({name, "_pulses_left"}, exp_q.size(), 0);
    check({name, "_busy_left"}, busy_q.size(), 0);
    exp_q.delete();
    busy_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_data = '0; bus.data_we = 1'b0;
    bus.wr_config = '0; bus.config_we = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rd_config", bus.rd_config, 16'h0001);
    check("rst_rd_status", bus.rd_status, 0);
    check("rst_status_changed", bus.status_changed, 0);
    check("rst_sl0", bus.sl0, 1);
    check("rst_sl1", bus.sl1, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset asserted mid-word
    write_cfg(16'h0402);
    #1 check("cfg_before_reset", bus.rd_config, 16'h0402);
    start_data(32'h0000005A);
    #1 check("busy_before_reset", bus.rd_status, 1);
    @(posedge clk);
    #3;
    check("line_low_before_reset", 32'(bus.sl0 & bus.sl1), 0);
    rst_n = 1'b0;
    #1;
    check("midrst_sl0", bus.sl0, 1);
    check("midrst_sl1", bus.sl1, 1);
    check("midrst_rd_status", bus.rd_status, 0);
    check("midrst_rd_config", bus.rd_config, 16'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    // Parity word: DIV=1, 8 bits, parity; A5 has four ones -> parity 1
    write_cfg(16'h0401);
    #1 check("cfg_0401", bus.rd_config, 16'h0401);
    push_word(32'h000000A5, 8, 1'b1, 1'b1, 2, 48);
    start_data(32'h000000A5);
    wait_done("par_word");

    // 32-bit all-ones, DIV=0; writes during busy must be ignored
    write_cfg(16'h0300);
    push_word(32'hFFFFFFFF, 32, 1'b0, 1'b0, 1, 70);
    start_data(32'hFFFFFFFF);
    repeat (10) @(negedge clk);
    bus.wr_data = 32'h0; bus.data_we = 1'b1;
    bus.wr_config = 16'h0002; bus.config_we = 1'b1;
    @(negedge clk);
    bus.data_we = 1'b0; bus.config_we = 1'b0;
    wait_done("word32");
    check("cfg_unchanged_busy", bus.rd_config, 16'h0300);

    // Same-cycle config+data: DIV=0, 8 bits, parity; data 1 -> parity 0
    push_word(32'h00000001, 8, 1'b1, 1'b0, 1, 24);
    @(negedge clk);
    bus.wr_config = 16'h0400; bus.config_we = 1'b1;
    bus.wr_data = 32'h00000001; bus.data_we = 1'b1;
    @(negedge clk);
    bus.config_we = 1'b0; bus.data_we = 1'b0;
    wait_done("same_cycle");
    check("cfg_0400", bus.rd_config, 16'h0400);

    // 16-bit, DIV=2, upper half of data discarded: (16+3)*2*3 = 114
    write_cfg(16'h0102);
    push_word(32'h12348001, 16, 1'b0, 1'b0, 3, 114);
    start_data(32'h12348001);
    wait_done("word16");

    // Parity injection bit
    write_cfg(16'h0C00);
`ifdef SL_TX_PARITY_INJECT_EN
    #1 check("cfg_0c00", bus.rd_config, 16'h0C00);
    push_word(32'h00000001, 8, 1'b1, 1'b1, 1, 24);
`else
    #1 check("cfg_0c00_masked", bus.rd_config, 16'h0400);
    push_word(32'h00000001, 8, 1'b1, 1'b0, 1, 24);
`endif
    start_data(32'h00000001);
    wait_done("inject");

    // Reserved bits
    write_cfg(16'hFFFF);
`ifdef SL_TX_PARITY_INJECT_EN
    #1 check("cfg_reserved", bus.rd_config, 16'h0FFF);
`else
    #1 check("cfg_reserved", bus.rd_config, 16'h07FF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
